// File: rtl/load_store_unit.sv
// RV32I load/store unit over a single-port word memory with one-cycle read latency.
// Sub-word stores use read-modify-write; misaligned, out-of-range or illegal requests are rejected.
module load_store_unit #(
    parameter int unsigned MEM_AW = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, DATA, WRITE} state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign req_ready = (r_state == IDLE);

    always_comb begin
        w_err = 1'b0;
        if (req_we)
            w_err = (req_funct3 > 3'b010);
        else
            w_err = (req_funct3 inside {3'b011, 3'b110, 3'b111});
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            w_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            w_err = 1'b1;
        if (req_addr[31:MEM_AW+2] != '0)
            w_err = 1'b1;
    end

    // The same lane selection serves both load extraction and the RMW merge.
    always_comb begin
        w_byte = mem_read_data[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h000000, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0000, w_half};
            default: w_load = mem_read_data;
        endcase
        w_merged = mem_read_data;
        if (r_funct3[0])
            w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
        else
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_we           <= 1'b0;
            r_funct3       <= '0;
            r_off          <= '0;
            r_wdata        <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            r_we     <= req_we;
                            r_funct3 <= req_funct3;
                            r_off    <= req_addr[1:0];
                            r_wdata  <= req_wdata[15:0];
                            mem_addr <= {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
                            if (req_we && req_funct3 == 3'b010) begin
                                mem_write_en   <= 1'b1;
                                mem_write_data <= req_wdata;
                                r_state        <= WRITE;
                            end else begin
                                r_state <= READ;
                            end
                        end
                    end
                end
                READ: r_state <= DATA;
                DATA: begin
                    if (r_we) begin
                        mem_write_data <= w_merged;
                        mem_write_en   <= 1'b1;
                        r_state        <= WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load;
                        resp_err   <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                WRITE: begin
                    mem_write_en <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= '0;
                    resp_err     <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 12, meaning the memory word-index width (2^MEM_AW 32-bit words; 4096 words = 16 KB).
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid  input  1  core request present.
REQ-005 The block SHALL have port req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3  input  3  RV32I size code: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-010 The block SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata  output  32  load result, already extended.
REQ-012 The block SHALL have port resp_err  output  1  request rejected, qualified by resp_valid.
REQ-013 The block SHALL have port mem_write_en  output  1  memory word write strobe.
REQ-014 The block SHALL have port mem_addr  output  32  memory word index, zero-extended.
REQ-015 The block SHALL have port mem_write_data  output  32  memory write word.
REQ-016 The block SHALL have port mem_read_data  input  32  memory read word, valid the cycle after mem_addr is sampled.

Function
REQ-017 The FSM SHALL have states IDLE, READ, DATA, WRITE; a request is accepted at the rising edge where req_valid && req_ready, and the funct3, we, address and wdata are latched at that edge.
REQ-018 At acceptance, an error SHALL be flagged when funct3 is illegal (load 011/110/111, store >010), when lh/lhu/sh has addr[0]=1, when lw/sw has addr[1:0]!=0, or when addr >= 4*2^MEM_AW.
REQ-019 An errored request SHALL NOT touch memory; the FSM SHALL stay in IDLE, with resp_valid=1, resp_err=1 and resp_rdata=0 in the next cycle.
REQ-020 Load transitions: IDLE->READ->DATA->IDLE; mem_addr = addr[MEM_AW+1:2] is held from READ onward; result is captured at the DATA edge; resp_valid is asserted in the cycle after accept edge N+2.
REQ-021 Load extraction SHALL be little-endian with byte lane k=addr[1:0]: lb/lbu select bits [8k+7:8k], lh/lhu select half addr[1], lw selects the whole word; lb/lh are sign-extended and lbu/lhu zero-extended.
REQ-022 sw transitions: IDLE->WRITE->IDLE; mem_write_en=1 and mem_write_data=wdata are driven during WRITE only; resp_valid follows edge N+1.
REQ-023 sb/sh transitions (read-modify-write): IDLE->READ->DATA->WRITE->IDLE; in DATA the merged word is registered (sb replaces lane k with wdata[7:0], sh replaces half addr[1] with wdata[15:0], other bytes unchanged); the write occurs at edge N+3; resp_valid follows edge N+3.
REQ-024 For stores, resp_rdata SHALL be 0 and resp_err 0.
REQ-025 mem_write_en SHALL be high only in WRITE and never in READ/DATA/IDLE.
REQ-026 resp_valid SHALL be a single-cycle pulse; a new request MAY be accepted in the same cycle resp_valid is high (back-to-back, no bubble beyond FSM latency).
REQ-027 req_ready SHALL be decoded from state (1 iff IDLE), with no combinational path from req_valid.
REQ-028 resp_rdata and resp_err SHALL hold their last values until the next response.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_write_en=0, mem_addr=0, mem_write_data=0; req_ready=1 after release.
REQ-030 A reset asserted mid-operation SHALL abort the operation with no write strobe and no response; memory contents are not reset.

Verification
REQ-031 Memory word 0x10 = 0x8899AABB; lb at 0x43 -> resp_rdata 0xFFFFFF88 at N+3; lbu at 0x43 -> 0x00000088.
REQ-032 lh at 0x42 -> 0xFFFF8899; lhu at 0x40 -> 0x0000AABB.
REQ-033 sb wdata 0x12 at 0x41 on word 0x8899AABB -> single write of 0x889912BB to index 0x10 at edge N+3; no other mem_write_en.
REQ-034 sw at 0x44, then lw at 0x44 back-to-back -> lw returns the stored value.
REQ-035 lw at 0x42, sh at 0x01, funct3=011 load, lw at 0x4000 -> each gives resp_err=1 the cycle after accept, with no mem_write_en.
REQ-036 rst_n pulsed low during WRITE of an sb -> mem_write_en drops immediately, no resp_valid, req_ready=1 after release.
